// File: rtl/branch_stat_cnt_if.sv
// CPU register port plus BTB statistics strobes for branch_stat_cnt; master = CPU/BTB side, slave = counter block.
// rdata/rdata_vld/sat are the only block-driven signals; every strobe and request is single-cycle.
interface branch_stat_cnt_if;
    logic        inc_br_cnt;
    logic        inc_hit_cnt;
    logic        inc_mispr_cnt;
    logic        cs;
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        rdata_vld;
    logic        sat;

    modport master (
        output inc_br_cnt, inc_hit_cnt, inc_mispr_cnt, cs, we, re, addr, wdata,
        input  rdata, rdata_vld, sat
    );

    modport slave (
        input  inc_br_cnt, inc_hit_cnt, inc_mispr_cnt, cs, we, re, addr, wdata,
        output rdata, rdata_vld, sat
    );
endinterface

// File: rtl/branch_stat_cnt.sv
// BTB statistics counters (branches, hits, mispredicts, enabled cycles) behind a 16-bit register port.
// Read latency 1 cycle, a read is accepted every cycle, and there is no backpressure.
module branch_stat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    branch_stat_cnt_if.slave    bus
);
    localparam int HI_W = CNT_W - 16;

    logic [CNT_W-1:0]          cnt_br;
    logic [CNT_W-1:0]          cnt_hit;
    logic [CNT_W-1:0]          cnt_mispr;
    logic [CNT_W-1:0]          cnt_cyc;
    logic [3:0][HI_W-1:0]      shd;
    logic                      en;
    logic                      frz;
    logic [3:0]                satf;
    logic [15:0]               rdata_q;
    logic                      rdata_vld_q;
    logic                      sat_q;

    logic [3:0][CNT_W-1:0]     cnt_all;
    logic [3:0][CNT_W-1:0]     cnt_nxt;
    logic [3:0]                inc;
    logic [3:0]                sat_evt;
    logic [3:0]                w1c;
    logic [3:0]                satf_nxt;
    logic [1:0]                sel;
    logic [15:0]               rd_mux;
    logic                      rd_acc;
    logic                      wr_acc;
    logic                      ctrl_wr;
    logic                      clr;
    logic                      unused_wdata;

    assign cnt_all      = {cnt_cyc, cnt_mispr, cnt_hit, cnt_br};
    assign inc          = {1'b1, bus.inc_mispr_cnt, bus.inc_hit_cnt, bus.inc_br_cnt};
    assign rd_acc       = bus.cs & bus.re & ~bus.we;
    assign wr_acc       = bus.cs & bus.we;
    assign ctrl_wr      = wr_acc && (bus.addr == 4'd8);
    assign clr          = ctrl_wr & bus.wdata[1];
    assign w1c          = (wr_acc && (bus.addr == 4'd9)) ? bus.wdata[3:0] : 4'b0;
    assign sel          = bus.addr[2:1];
    assign unused_wdata = ^bus.wdata[15:4];

    // Clear beats any same-cycle strobe; a strobe on a saturated counter only raises its flag.
    always_comb begin
        cnt_nxt = cnt_all;
        sat_evt = '0;
        for (int k = 0; k < 4; k++) begin
            if (clr) begin
                cnt_nxt[k] = '0;
            end else if (inc[k] && en && !frz) begin
                if (&cnt_all[k]) begin
                    sat_evt[k] = 1'b1;
                end else begin
                    cnt_nxt[k] = cnt_all[k] + CNT_W'(1);
                end
            end
        end
    end

    // A set event outranks a same-cycle write-1-to-clear.
    assign satf_nxt = (satf & ~w1c) | sat_evt;

    always_comb begin
        rd_mux = '0;
        if (!bus.addr[3]) begin
            rd_mux = bus.addr[0] ? 16'(shd[sel]) : cnt_all[sel][15:0];
        end else if (bus.addr == 4'd8) begin
            rd_mux = {13'b0, frz, 1'b0, en};
        end else if (bus.addr == 4'd9) begin
            rd_mux = {12'b0, satf};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_br      <= '0;
            cnt_hit     <= '0;
            cnt_mispr   <= '0;
            cnt_cyc     <= '0;
            shd         <= '0;
            en          <= 1'b1;
            frz         <= 1'b0;
            satf        <= '0;
            sat_q       <= 1'b0;
            rdata_q     <= '0;
            rdata_vld_q <= 1'b0;
        end else begin
            cnt_br      <= cnt_nxt[0];
            cnt_hit     <= cnt_nxt[1];
            cnt_mispr   <= cnt_nxt[2];
            cnt_cyc     <= cnt_nxt[3];
            satf        <= satf_nxt;
            sat_q       <= |satf_nxt;
            rdata_vld_q <= rd_acc;
            if (ctrl_wr) begin
                en  <= bus.wdata[0];
                frz <= bus.wdata[2];
            end
            // Reading a low half freezes the matching high half so a lo/hi pair is coherent.
            if (clr) begin
                shd <= '0;
            end else if (rd_acc && !bus.addr[3] && !bus.addr[0]) begin
                shd[sel] <= cnt_all[sel][CNT_W-1:16];
            end
            if (rd_acc) begin
                rdata_q <= rd_mux;
            end
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.rdata_vld = rdata_vld_q;
    assign bus.sat       = sat_q;
endmodule
